// File: rtl/updi_uart_tx.sv
// UPDI serial transmitter: pops one byte at a time from the upstream fifo and sends it
// as start + 8 data (LSB first) + even parity + 2 stop bits on a shared single-wire pad.
module updi_uart_tx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] fifo_out,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             tx_oe,
  output logic             busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [WIDTH-1:0] shift, shift_d;
  logic             parity, parity_d;
  logic             tx_d, tx_oe_d, rd_en_d;
  logic             bit_done;
  logic [CW-1:0]    cnt_dec;

  assign bit_done = (cnt == '0);
  assign cnt_dec  = cnt - CW'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      tx         <= 1'b1;
      tx_oe      <= 1'b0;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shift      <= shift_d;
      parity     <= parity_d;
      tx         <= tx_d;
      tx_oe      <= tx_oe_d;
      fifo_rd_en <= rd_en_d;
    end
  end

  // Every output is computed here and registered above, so nothing combinational reaches the pins.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shift_d  = shift;
    parity_d = parity;
    tx_d     = tx;
    tx_oe_d  = tx_oe;
    rd_en_d  = 1'b0;

    case (state)
      IDLE: begin
        tx_d    = 1'b1;
        tx_oe_d = 1'b0;
        if (en && !fifo_empty) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d  = fifo_out;
        parity_d = ^fifo_out;
        cnt_d    = CNT_MAX;
        idx_d    = '0;
        tx_d     = 1'b0;
        tx_oe_d  = 1'b1;
        state_d  = START;
      end

      START: begin
        if (bit_done) begin
          cnt_d   = CNT_MAX;
          idx_d   = '0;
          tx_d    = shift[0];
          shift_d = shift >> 1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_d = CNT_MAX;
          if (idx == LAST_BIT) begin
            tx_d    = parity;
            state_d = PARITY;
          end else begin
            tx_d    = shift[0];
            shift_d = shift >> 1;
            idx_d   = idx + 3'd1;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end

      PARITY: begin
        if (bit_done) begin
          cnt_d   = CNT_MAX;
          idx_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      // idx is reused to count the two stop bits.
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (idx == 3'd1) begin
            cnt_d   = '0;
            idx_d   = '0;
            tx_oe_d = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = CNT_MAX;
            idx_d = 3'd1;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end

      default: begin
        tx_d    = 1'b1;
        tx_oe_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_updi_uart_tx.sv
// Bench for updi_uart_tx: two instances (4 and 2 clocks per bit) fed by fifo models;
// a per-instance monitor decodes frames off the pad and scores them against a queue.
module tb_updi_uart_tx;

  localparam int C0 = 4;
  localparam int C1 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en_w;
  logic [1:0] tx_w, tx_oe_w, busy_w, rd_en_w, fifo_empty_w;
  logic [7:0] fifo_out_w [2];
  logic [7:0] mem [2][32];
  logic [1:0] prev_rd;
  logic [1:0] abort_armed;

  int checks = 0;
  int errors = 0;
  int wr_ptr [2];
  int rd_ptr [2];
  int pops [2];
  int frames_done [2];
  int gap_last [2];
  int bad_pops = 0;
  int double_pulse = 0;

  logic [11:0] exp_q0 [$];
  logic [11:0] exp_q1 [$];

  always #5 clk = ~clk;

  updi_uart_tx #(.CLKS_PER_BIT(C0), .WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .en(en_w[0]), .fifo_out(fifo_out_w[0]),
    .fifo_empty(fifo_empty_w[0]), .fifo_rd_en(rd_en_w[0]),
    .tx(tx_w[0]), .tx_oe(tx_oe_w[0]), .busy(busy_w[0])
  );

  updi_uart_tx #(.CLKS_PER_BIT(C1), .WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .en(en_w[1]), .fifo_out(fifo_out_w[1]),
    .fifo_empty(fifo_empty_w[1]), .fifo_rd_en(rd_en_w[1]),
    .tx(tx_w[1]), .tx_oe(tx_oe_w[1]), .busy(busy_w[1])
  );

  assign fifo_empty_w[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty_w[1] = (wr_ptr[1] == rd_ptr[1]);

  // Fifo read side: data appears the cycle after a pop; illegal pops are tallied.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en_w[k] === 1'b1) begin
        if (wr_ptr[k] == rd_ptr[k]) bad_pops++;
        if (prev_rd[k] === 1'b1) double_pulse++;
        fifo_out_w[k] <= mem[k][rd_ptr[k] % 32];
        rd_ptr[k] <= rd_ptr[k] + 1;
        pops[k] <= pops[k] + 1;
      end
      prev_rd[k] <= rd_en_w[k];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] b, input logic [11:0] frame);
    mem[k][wr_ptr[k] % 32] = b;
    wr_ptr[k] = wr_ptr[k] + 1;
    if (k == 0) exp_q0.push_back(frame);
    else exp_q1.push_back(frame);
  endtask

  function automatic logic [11:0] frame_of(input logic [7:0] b);
    return {2'b11, ^b, b, 1'b0};
  endfunction

  task automatic popExp(input int k, output logic [11:0] e, output bit ok);
    ok = 1'b1;
    e  = '0;
    if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
    else if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    else ok = 1'b0;
  endtask

  task automatic monitor(input int k, input int cpb);
    int          zeros;
    int          n;
    logic [11:0] got, e;
    bit          ok;
    zeros = 0;
    forever begin
      @(negedge clk);
      if (tx_oe_w[k] !== 1'b1) begin
        zeros++;
        continue;
      end
      gap_last[k] = zeros;
      got = '0;
      n = 0;
      for (int c = 0; c < 12 * cpb; c++) begin
        if (c > 0) @(negedge clk);
        if (tx_oe_w[k] !== 1'b1) break;
        n++;
        if (c % cpb == cpb / 2) got[c / cpb] = tx_w[k];
      end
      if (n < 12 * cpb) begin
        if (abort_armed[k]) begin
          abort_armed[k] = 1'b0;
          popExp(k, e, ok);
        end else begin
          checkOutput($sformatf("oe_len_%0d", k), n, 12 * cpb);
        end
        zeros = 1;
      end else begin
        @(negedge clk);
        checkOutput($sformatf("oe_release_%0d", k), tx_oe_w[k], 1'b0);
        popExp(k, e, ok);
        if (!ok) checkOutput($sformatf("unexpected_frame_%0d", k), got, 12'h0);
        else checkOutput($sformatf("frame_%0d", k), got, e);
        frames_done[k]++;
        zeros = (tx_oe_w[k] === 1'b0) ? 1 : 0;
      end
    end
  endtask

  initial monitor(0, C0);
  initial monitor(1, C1);

  task automatic waitFrames(input int k, input int target, input int budget);
    for (int i = 0; i < budget && frames_done[k] < target; i++) @(negedge clk);
    checkOutput($sformatf("frames_done_%0d", k), frames_done[k], target);
  endtask

  task automatic waitOe(input int k, input int budget);
    for (int i = 0; i < budget && tx_oe_w[k] !== 1'b1; i++) @(negedge clk);
    checkOutput($sformatf("oe_start_%0d", k), tx_oe_w[k], 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    int lat;
    int oe_cnt;
    int p0;
    int f0;
    en_w        = 2'b00;
    abort_armed = 2'b00;
    prev_rd     = 2'b00;

    // Reset and quiet idle with an empty fifo
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_tx", tx_w[0], 1'b1);
    checkOutput("rst_oe", tx_oe_w[0], 1'b0);
    checkOutput("rst_rd_en", rd_en_w[0], 1'b0);
    checkOutput("rst_busy", busy_w[0], 1'b0);
    en_w[0] = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || tx_oe_w[0] !== 1'b0 || rd_en_w[0] !== 1'b0 || busy_w[0] !== 1'b0) bad++;
    end
    checkOutput("idle_quiet", bad, 0);
    checkOutput("idle_pops", pops[0], 0);

    // Single byte 0x55: latency, line enable length, frame contents
    p0 = pops[0];
    applyStimulus(0, 8'h55, 12'hCAA);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (tx_w[0] === 1'b0) begin
        lat = n;
        break;
      end
    end
    checkOutput("start_latency", lat, 3);
    oe_cnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_oe_w[0] !== 1'b1) break;
      oe_cnt++;
    end
    checkOutput("oe_cycles_55", oe_cnt, 48);
    waitFrames(0, 1, 100);
    checkOutput("pops_55", pops[0] - p0, 1);

    // Back-to-back 0x01 (odd parity) then 0x03 (even parity)
    p0 = pops[0];
    applyStimulus(0, 8'h01, 12'hE02);
    applyStimulus(0, 8'h03, 12'hC06);
    waitFrames(0, 3, 200);
    checkOutput("b2b_gap", gap_last[0], 3);
    checkOutput("b2b_empty", fifo_empty_w[0], 1'b1);
    checkOutput("b2b_pops", pops[0] - p0, 2);

    // en gating: no pop while low, frame in flight survives en dropping
    en_w[0] = 1'b0;
    p0 = pops[0];
    applyStimulus(0, 8'h3C, 12'hC78);
    applyStimulus(0, 8'hA7, 12'hF4E);
    repeat (20) @(negedge clk);
    checkOutput("en_low_pops", pops[0] - p0, 0);
    checkOutput("en_low_busy", busy_w[0], 1'b0);
    en_w[0] = 1'b1;
    waitOe(0, 20);
    repeat (2 * C0) @(negedge clk);
    en_w[0] = 1'b0;
    waitFrames(0, 4, 100);
    repeat (30) @(negedge clk);
    checkOutput("en_drop_pops", pops[0] - p0, 1);
    checkOutput("en_drop_busy", busy_w[0], 1'b0);
    en_w[0] = 1'b1;
    waitFrames(0, 5, 100);
    checkOutput("en_resume_pops", pops[0] - p0, 2);

    // Reset during data bit 3 aborts the frame and the byte is not re-sent
    p0 = pops[0];
    applyStimulus(0, 8'h96, 12'hD2C);
    waitOe(0, 20);
    repeat (C0 + 3 * C0 + 1) @(negedge clk);
    abort_armed[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_tx", tx_w[0], 1'b1);
    checkOutput("abort_oe", tx_oe_w[0], 1'b0);
    checkOutput("abort_busy", busy_w[0], 1'b0);
    rst = 1'b0;
    f0 = frames_done[0];
    repeat (40) @(negedge clk);
    checkOutput("abort_pops", pops[0] - p0, 1);
    checkOutput("abort_no_resend", frames_done[0] - f0, 0);
    checkOutput("abort_discarded", exp_q0.size(), 0);
    applyStimulus(0, 8'h00, 12'hC00);
    waitFrames(0, f0 + 1, 100);

    // Full fifo burst at two clocks per bit
    en_w[1] = 1'b1;
    for (int i = 0; i < 31; i++) applyStimulus(1, 8'(i), frame_of(8'(i)));
    waitFrames(1, 31, 31 * 12 * C1 + 200);
    checkOutput("burst_empty", fifo_empty_w[1], 1'b1);
    checkOutput("burst_pops", pops[1], 31);

    repeat (5) @(negedge clk);
    checkOutput("pop_on_empty", bad_pops, 0);
    checkOutput("rd_en_pulse", double_pulse, 0);
    checkOutput("leftover_q0", exp_q0.size(), 0);
    checkOutput("leftover_q1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updi_uart_tx.md
Name: updi_uart_tx

Overview:
- Serial transmit stage directly downstream of the byte fifo.
- Pops bytes from the fifo and serialises each as a UPDI frame: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits.
- Drives the single-wire UPDI line through an output-enable, so the pad can be shared with the receiver.
- Holds the line released (idle high) whenever it is not transmitting.

Parameters:
- CLKS_PER_BIT, 100, clk cycles per UART bit; legal range is ≥2.
- WIDTH, 8, data width; fixed at 8 for UPDI, kept to match the fifo parameter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  permits starting a new frame; a frame in progress always completes.
- fifo_out  input  WIDTH  fifo read data; valid the cycle after a fifo_rd_en cycle.
- fifo_empty  input  1  fifo empty flag.
- fifo_rd_en  output  1  fifo pop request; single-cycle pulse, registered.
- tx  output  1  serial data to the pad; registered.
- tx_oe  output  1  pad drive enable; 1 = drive tx, 0 = release to pull-up.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, tx=1, tx_oe=0, fifo_rd_en=0, busy=0, and all counters 0.
- Reset mid-frame aborts on the next edge: tx=1 and tx_oe=0 immediately. The partially sent byte is lost and is not re-popped.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_oe=0.
  - If en && !fifo_empty at an edge: next state FETCH, fifo_rd_en<=1.
- FETCH:
  - fifo_rd_en is high for this one cycle only.
  - The fifo pops at the closing edge. Next state LOAD, fifo_rd_en<=0.
- LOAD:
  - Capture fifo_out into the shift register.
  - parity <= XOR of all 8 bits (even parity).
  - Next state START; at that edge tx<=0 and tx_oe<=1.
- Latency: from the IDLE cycle that sees non-empty to tx falling is exactly 3 edges.
- Bit timing:
  - Every bit (start, data, parity, stop) is held exactly CLKS_PER_BIT cycles.
  - A down-counter of width $clog2(CLKS_PER_BIT) reloads at each bit boundary.
- START: after one bit time go to DATA, tx<=shift[0].
- DATA:
  - The 3-bit index counts 0..7; shift right at each bit boundary.
  - After bit 7: tx<=parity, go to PARITY.
- PARITY: after one bit time go to STOP, tx<=1.
- STOP:
  - Lasts 2 bit times (2*CLKS_PER_BIT cycles), tx=1, tx_oe=1.
  - On completion: tx_oe<=0, go to IDLE.
- Full frame: 12*CLKS_PER_BIT cycles of tx_oe=1.
- Back-to-back bytes: inter-frame gap is exactly 3 cycles (IDLE, FETCH, LOAD) with tx=1 and tx_oe=0.
- en low:
  - Never blocks a frame already past IDLE.
  - en deasserted during FETCH/LOAD: the byte is still sent.
- fifo_empty:
  - Sampled only in IDLE.
  - fifo_rd_en is never asserted while fifo_empty=1 or while state is not IDLE/FETCH.
  - A pop never occurs on an empty fifo.
- busy is 1 from the edge entering FETCH until the edge returning to IDLE.
- fifo_out is ignored except in LOAD; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, CLKS_PER_BIT=4, fifo empty, en=1 for 100 cycles -> tx=1, tx_oe=0, fifo_rd_en never 1, busy=0.
- Push 0x55, en=1:
  - fifo_rd_en is high exactly 1 cycle; tx falls 3 edges after non-empty is seen.
  - Sampled mid-bit, tx = 0,1,0,1,0,1,0,1,0,p=0,1,1.
  - tx_oe high for exactly 48 cycles.
- Push 0x01 then 0x03 back-to-back:
  - 0x01 frame has parity 1; 0x03 frame has parity 0.
  - Gap between the frames is exactly 3 cycles with tx_oe=0.
  - fifo_empty=1 after the second pop.
- en=0 with 2 bytes queued -> no pop. Raise en -> frame starts. Drop en during DATA -> the frame completes with 12 bits, and no second pop until en returns to 1.
- Assert rst for 1 cycle during DATA bit 3 -> next edge: tx=1, tx_oe=0, busy=0; no further pop occurs until the fifo is non-empty and en=1.
- CLKS_PER_BIT=2, 31 bytes 0..30 (fifo full) -> all bytes are transmitted in order with correct parity, and fifo_empty=1 at the end.
